// File: rtl/kiss_fsm_sequencer.sv
// Stimulus/check sequencer for a 4-in/2-out KISS FSM: resets it, replays stored vectors, compares outputs.
// Latency: start sampled -> 1 CLR cycle -> len+1 RUN cycles -> 1-cycle done pulse.
// No backpressure: one vector per clock; abort returns to IDLE immediately, program writes ignored while busy.
module kiss_fsm_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int CW    = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [5:0]    wr_data,
    input  logic [AW-1:0] len,
    input  logic          start,
    input  logic          abort,
    input  logic          loop_en,
    input  logic          stop_on_err,
    output logic          fsm_rst,
    output logic [3:0]    fsm_in,
    input  logic [1:0]    fsm_out,
    output logic          busy,
    output logic          done,
    output logic          err_flag,
    output logic [CW-1:0] err_cnt,
    output logic [AW-1:0] first_err_addr
);

    typedef enum logic [1:0] {S_IDLE, S_CLR, S_RUN, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] len_q;
    logic          loop_q;
    logic          stop_q;
    logic [5:0]    mem [DEPTH];
    logic [5:0]    cur_entry;
    logic          go;
    logic          mismatch;
    logic          at_end;

    // Entry under the pointer; [5:2] is the stimulus, [1:0] the expected FSM output.
    assign cur_entry = mem[ptr_q];
    // A run is accepted only from IDLE, and abort on the same cycle cancels it.
    assign go        = (state_q == S_IDLE) && start && !abort;
    assign mismatch  = (state_q == S_RUN) && (fsm_out != cur_entry[1:0]);
    assign at_end    = (ptr_q == len_q);

    // Status and stimulus decoded from the state so async reset clears them at once.
    assign busy    = (state_q == S_CLR) || (state_q == S_RUN);
    assign done    = (state_q == S_DONE);
    assign fsm_rst = (state_q == S_CLR);
    assign fsm_in  = (state_q == S_RUN) ? cur_entry[5:2] : 4'b0000;

    // Program memory: not reset, so contents survive a mid-run reset.
    always_ff @(posedge clock) begin
        if (wr_en && !busy) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // State and pointer registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Run configuration is captured when a run is accepted and held for its duration.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            len_q  <= '0;
            loop_q <= 1'b0;
            stop_q <= 1'b0;
        end else if (go) begin
            len_q  <= len;
            loop_q <= loop_en;
            stop_q <= stop_on_err;
        end
    end

    // Next state and pointer: abort outranks stop-on-error, which outranks end-of-sequence.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                ptr_d = '0;
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (stop_q && mismatch) begin
                    state_d = S_DONE;
                end else if (at_end) begin
                    if (loop_q) begin
                        ptr_d = '0;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    ptr_d = ptr_q + AW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Error results: cleared by an accepted start, frozen by abort, counter saturates.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_cnt        <= '0;
            err_flag       <= 1'b0;
            first_err_addr <= '0;
        end else if (go) begin
            err_cnt        <= '0;
            err_flag       <= 1'b0;
            first_err_addr <= '0;
        end else if (mismatch && !abort) begin
            if (err_cnt != {CW{1'b1}}) begin
                err_cnt <= err_cnt + CW'(1);
            end
            if (!err_flag) begin
                err_flag       <= 1'b1;
                first_err_addr <= ptr_q;
            end
        end
    end

endmodule

// File: tb/tb_kiss_fsm_sequencer.sv
// Bench for kiss_fsm_sequencer with a small bbara-like downstream FSM model.
// Table-driven runs plus hand sequences for loop/saturation, abort, write lockout, async reset.
// Expected stimulus and results are queued at start and popped as the DUT produces them.
module tb_kiss_fsm_sequencer;

    localparam int AW = 4;
    localparam int CW = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [5:0]    wr_data;
    logic [AW-1:0] len;
    logic          start;
    logic          abort;
    logic          loop_en;
    logic          stop_on_err;
    logic          fsm_rst;
    logic [3:0]    fsm_in;
    logic [1:0]    fsm_out;
    logic          busy;
    logic          done;
    logic          err_flag;
    logic [CW-1:0] err_cnt;
    logic [AW-1:0] first_err_addr;

    kiss_fsm_sequencer #(.DEPTH(16), .AW(AW), .CW(CW)) dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .len(len), .start(start), .abort(abort), .loop_en(loop_en), .stop_on_err(stop_on_err),
        .fsm_rst(fsm_rst), .fsm_in(fsm_in), .fsm_out(fsm_out), .busy(busy), .done(done),
        .err_flag(err_flag), .err_cnt(err_cnt), .first_err_addr(first_err_addr)
    );

    always #5 clock = ~clock;

    // Downstream model: counts consecutive 0111 inputs; output 10 when at count 3 and input is hold.
    logic [1:0] dcnt;
    always @(posedge clock or posedge reset) begin
        if (reset) dcnt <= 2'd0;
        else if (fsm_rst) dcnt <= 2'd0;
        else if (fsm_in == 4'h7) begin
            if (dcnt != 2'd3) dcnt <= dcnt + 2'd1;
        end else if (fsm_in != 4'h0) dcnt <= 2'd0;
    end
    assign fsm_out = (dcnt == 2'd3 && fsm_in == 4'h0) ? 2'b10 : 2'b00;

    typedef struct {
        logic [1:0] exp1;
        logic [1:0] exp3;
        logic       stop;
        logic [3:0] ln;
        int         run;
        int         e_cnt;
        int         e_flag;
        int         e_first;
    } vec_t;

    typedef struct {
        int cnt;
        int flag;
        int first;
        int dcyc;
    } res_t;

    int         total = 0;
    int         bad   = 0;
    logic [3:0] exp_in_q[$];
    res_t       res_q[$];
    vec_t       tbl[6];
    logic [3:0] stim[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    function automatic vec_t mk(input logic [1:0] e1, input logic [1:0] e3, input logic st,
                                input logic [3:0] ln, input int run, input int c, input int f,
                                input int fa);
        vec_t v;
        v.exp1 = e1; v.exp3 = e3; v.stop = st; v.ln = ln; v.run = run;
        v.e_cnt = c; v.e_flag = f; v.e_first = fa;
        return v;
    endfunction

    task automatic prog(input vec_t v);
        logic [5:0] d[4];
        d[0] = {4'h7, 2'b00};
        d[1] = {4'h7, v.exp1};
        d[2] = {4'h7, 2'b00};
        d[3] = {4'h0, v.exp3};
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = d[i];
            step();
        end
        wr_en = 1'b0;
    endtask

    // One complete run; lock_at >= 0 injects a write and a start at that RUN cycle and a start on done.
    task automatic run_vec(input vec_t v, input bit do_prog, input int lock_at, input string tag);
        res_t r;
        int   cyc;
        int   rst_cnt;
        int   run_cnt;
        bit   got_done;
        logic [3:0] e;
        if (do_prog) prog(v);
        len = v.ln; loop_en = 1'b0; stop_on_err = v.stop;
        exp_in_q.delete();
        for (int i = 0; i < v.run; i++) exp_in_q.push_back(stim[i]);
        r.cnt = v.e_cnt; r.flag = v.e_flag; r.first = v.e_first; r.dcyc = 2 + v.run;
        res_q.push_back(r);
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 1; rst_cnt = 0; run_cnt = 0; got_done = 0;
        while (1) begin
            if (fsm_rst) begin
                rst_cnt++;
                check({tag, "_clr_fsm_in"}, 32'(fsm_in), 0);
            end else if (busy) begin
                run_cnt++;
                if (exp_in_q.size() == 0) begin
                    check({tag, "_extra_run_cycle"}, 32'(run_cnt), 32'(v.run));
                end else begin
                    e = exp_in_q.pop_front();
                    check({tag, "_fsm_in"}, 32'(fsm_in), 32'(e));
                end
            end
            if (lock_at >= 0 && run_cnt == lock_at && busy && !fsm_rst) begin
                wr_en = 1'b1; wr_addr = '0; wr_data = 6'h3f; start = 1'b1;
            end else begin
                wr_en = 1'b0; start = 1'b0;
            end
            if (done) got_done = 1;
            if (got_done || cyc >= 60) break;
            step();
            cyc++;
        end
        wr_en = 1'b0; start = 1'b0;
        check({tag, "_done_seen"}, 32'(got_done), 1);
        r = res_q.pop_front();
        check({tag, "_done_cycle"}, 32'(cyc), 32'(r.dcyc));
        check({tag, "_run_cycles"}, 32'(run_cnt), 32'(v.run));
        check({tag, "_rst_cycles"}, 32'(rst_cnt), 1);
        check({tag, "_stim_left"}, 32'(exp_in_q.size()), 0);
        check({tag, "_err_cnt"}, 32'(err_cnt), 32'(r.cnt));
        check({tag, "_err_flag"}, 32'(err_flag), 32'(r.flag));
        check({tag, "_first_err"}, 32'(first_err_addr), 32'(r.first));
        if (lock_at >= 0) start = 1'b1;
        step();
        start = 1'b0;
        check({tag, "_idle_busy"}, 32'(busy), 0);
        check({tag, "_idle_done"}, 32'(done), 0);
        check({tag, "_idle_fsm_in"}, 32'(fsm_in), 0);
    endtask

    initial begin
        int cyc;
        int run_cnt;
        int rst_cnt;
        bit seen_done;

        stim[0] = 4'h7; stim[1] = 4'h7; stim[2] = 4'h7; stim[3] = 4'h0;
        tbl[0] = mk(2'b00, 2'b10, 1'b0, 4'd3, 4, 0, 0, 0);
        tbl[1] = mk(2'b00, 2'b00, 1'b0, 4'd3, 4, 1, 1, 3);
        tbl[2] = mk(2'b10, 2'b10, 1'b1, 4'd3, 2, 1, 1, 1);
        tbl[3] = mk(2'b00, 2'b10, 1'b0, 4'd0, 1, 0, 0, 0);
        tbl[4] = mk(2'b10, 2'b00, 1'b0, 4'd3, 4, 2, 1, 1);
        tbl[5] = mk(2'b00, 2'b00, 1'b0, 4'd2, 3, 0, 0, 0);

        reset = 1'b1; wr_en = 0; wr_addr = '0; wr_data = '0; len = '0;
        start = 0; abort = 0; loop_en = 0; stop_on_err = 0;
        #12;
        @(negedge clock);
        reset = 1'b0;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_fsm_rst", 32'(fsm_rst), 0);
        check("rst_fsm_in", 32'(fsm_in), 0);
        check("rst_err_flag", 32'(err_flag), 0);
        check("rst_err_cnt", 32'(err_cnt), 0);
        check("rst_first", 32'(first_err_addr), 0);

        for (int i = 0; i < 6; i++) begin
            run_vec(tbl[i], 1, -1, $sformatf("vec%0d", i));
        end

        // Loop with a mismatch every pass: counter saturates, no done, abort ends it quietly.
        prog(tbl[1]);
        len = 4'd3; loop_en = 1'b1; stop_on_err = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 0; run_cnt = 0; rst_cnt = 0; seen_done = 0;
        while (1) begin
            if (fsm_rst) rst_cnt++;
            else if (busy) run_cnt++;
            if (done) seen_done = 1;
            if (run_cnt >= 21 || cyc >= 100) break;
            step();
            cyc++;
        end
        check("loop_run_cycles", 32'(run_cnt), 21);
        check("loop_rst_cycles", 32'(rst_cnt), 1);
        check("loop_no_done", 32'(seen_done), 0);
        check("loop_wrap_fsm_in", 32'(fsm_in), 7);
        check("loop_err_cnt_sat", 32'(err_cnt), 3);
        check("loop_err_flag", 32'(err_flag), 1);
        check("loop_first", 32'(first_err_addr), 3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_fsm_in", 32'(fsm_in), 0);
        check("abort_err_hold", 32'(err_cnt), 3);
        step();
        check("abort_no_late_done", 32'(done), 0);

        // start together with abort in IDLE: no run, results untouched.
        loop_en = 1'b0;
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        check("sa_busy", 32'(busy), 0);
        step();
        check("sa_busy2", 32'(busy), 0);
        check("sa_err_kept", 32'(err_cnt), 3);

        // Write lockout and start-while-busy, then readback run.
        run_vec(tbl[0], 1, 2, "lock");
        run_vec(tbl[0], 0, -1, "readback");

        // Asynchronous reset in the middle of a run.
        len = 4'd3; loop_en = 1'b0; stop_on_err = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("ar_pre_busy", 32'(busy), 1);
        check("ar_pre_fsm_in", 32'(fsm_in), 7);
        #2;
        reset = 1'b1;
        #1;
        check("ar_busy", 32'(busy), 0);
        check("ar_fsm_in", 32'(fsm_in), 0);
        check("ar_fsm_rst", 32'(fsm_rst), 0);
        check("ar_done", 32'(done), 0);
        check("ar_err_cnt", 32'(err_cnt), 0);
        @(negedge clock);
        reset = 1'b0;
        step();
        run_vec(tbl[0], 0, -1, "after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
